uart_rx_param: RTL and testbench

Parametrised UART receiver for the UART subsystem, replacing the fixed 8N1 receiver.
- Configurable data width, parity, stop bits and oversampling ratio.
- Majority-vote sampling, false-start rejection and per-frame framing and parity error flags.
- A one-entry output holding register with a valid/ready handshake and overrun reporting.
- Sits between the `rxd` pad and the consumer (register block or FIFO) in the same clock domain as the transmitter.

---
 rtl/uart_rx_param_if.sv | 30 +++
 rtl/uart_rx_param.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle of the parametrised UART receiver.
// The holding register drives data, flags and valid; the consumer drives ready.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  parity_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-of-3 vote, error flags, one-entry hold.
// Parity state and checker exist only with `UART_RX_PARITY_EN defined.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           rxd,
  output logic           busy,
  uart_rx_param_if.master rx
);
  localparam int SAMPLE_DIV =
    CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  localparam int DW =
    (SAMPLE_DIV < 2) ? 1 : $clog2(SAMPLE_DIV);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd3;
`endif

  generate
    if (OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0) begin : g_e_os
      $error("OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_e_db
      $error("DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_e_sb
      $error("STOP_BITS must be 1 or 2");
    end
    if (SAMPLE_DIV < 1) begin : g_e_div
      $error("SAMPLE_DIV must be >= 1");
    end
`ifdef UART_RX_PARITY_EN
    if (PARITY < 0 || PARITY > 2) begin : g_e_par
      $error("PARITY must be 0, 1 or 2");
    end
`else
    if (PARITY != 0) begin : g_w_par
      $warning("PARITY ignored: parity not built");
    end
`endif
  endgenerate

  logic                 rx_meta;
  logic                 rxs;
  logic                 armed;
  logic [2:0]           state;
  logic [DW-1:0]        div_cnt;
  logic [SW-1:0]        s_idx;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 smp0;
  logic                 smp1;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_p;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 perr_q;
  logic                 ovr_q;

  logic tick;
  logic wrap;
  logic vote_en;
  logic vote;
  logic last_stop;
  logic commit;

  assign tick    = (state != S_IDLE) &&
                   (div_cnt == DW'(SAMPLE_DIV - 1));
  assign wrap    = tick && (s_idx == SW'(OVERSAMPLE - 1));
  assign vote_en = tick && (s_idx == SW'(M + 1));
  assign vote    = (smp0 & smp1) | (smp0 & rxs) |
                   (smp1 & rxs);
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  assign commit  = vote_en && (state == S_STOP) && last_stop;

`ifdef UART_RX_PARITY_EN
  logic perr_p;
  logic exp_par;
  assign exp_par = (PARITY == 1) ? ~^shreg : ^shreg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      armed    <= 1'b0;
      state    <= S_IDLE;
      div_cnt  <= '0;
      s_idx    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      smp0     <= 1'b1;
      smp1     <= 1'b1;
      shreg    <= '0;
      ferr_p   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_p   <= 1'b0;
`endif
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      armed   <= armed | rxs;
      if (state == S_IDLE || tick) div_cnt <= '0;
      else div_cnt <= div_cnt + 1'b1;
      if (tick) s_idx <= wrap ? '0 : s_idx + 1'b1;
      if (tick && s_idx == SW'(M - 1)) smp0 <= rxs;
      if (tick && s_idx == SW'(M)) smp1 <= rxs;
      unique case (state)
        S_IDLE: begin
          s_idx    <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          ferr_p   <= 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_p   <= 1'b0;
`endif
          if (armed && !rxs) state <= S_START;
        end
        S_START: begin
          if (vote_en && vote) state <= S_IDLE;
          else if (wrap) state <= S_DATA;
        end
        S_DATA: begin
          if (vote_en) begin
            shreg   <= {vote, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (wrap && bit_cnt == BW'(DATA_BITS)) begin
`ifdef UART_RX_PARITY_EN
            state <= (PARITY != 0) ? S_PAR : S_STOP;
`else
            state <= S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PAR: begin
          if (vote_en && vote != exp_par) perr_p <= 1'b1;
          if (wrap) state <= S_STOP;
        end
`endif
        S_STOP: begin
          if (vote_en) begin
            if (!vote) ferr_p <= 1'b1;
            // leave mid-bit so the next start edge is caught
            if (last_stop) state <= S_IDLE;
            else stop_cnt <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (valid_q && rx.rx_ready) begin
        valid_q <= 1'b0;
        ferr_q  <= 1'b0;
        perr_q  <= 1'b0;
      end
      if (commit) begin
        if (!valid_q || rx.rx_ready) begin
          data_q  <= shreg;
          valid_q <= 1'b1;
          ferr_q  <= ferr_p | ~vote;
`ifdef UART_RX_PARITY_EN
          perr_q  <= perr_p;
`else
          perr_q  <= 1'b0;
`endif
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign rx.rx_data    = data_q;
  assign rx.rx_valid   = valid_q;
  assign rx.frame_err  = ferr_q;
  assign rx.parity_err = perr_q;
  assign rx.overrun    = ovr_q;
  assign busy          = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised bench for uart_rx_param against a frame-level model.
// Divider of 4 keeps the bit period at 64 clocks.
module tb_uart_rx_param;
  localparam int CLK_FREQ = 7_372_800;
  localparam int BAUD     = 115200;
  localparam int OS       = 16;
  localparam int T_BIT    = 64;
  localparam int DB       = 8;
  localparam int NSTOP    = 1;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 2;
`else
  localparam int PAR = 0;
`endif
  localparam bit PAR_EN = (PAR != 0);

  typedef struct packed {
    logic [DB-1:0] data;
    logic          ferr;
    logic          perr;
  } frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rxd = 1'b1;
  logic busy;

  uart_rx_param_if #(.DATA_BITS(DB)) rx_if ();

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD_RATE(BAUD),
    .OVERSAMPLE(OS),
    .DATA_BITS(DB),
    .PARITY(PAR),
    .STOP_BITS(NSTOP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rxd(rxd),
    .busy(busy),
    .rx(rx_if.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ovr_cycles = 0;
  frame_t got_q[$];

  always @(negedge clk) begin
    if (rx_if.rx_valid && rx_if.rx_ready)
      got_q.push_back(frame_t'({rx_if.rx_data,
        rx_if.frame_err, rx_if.parity_err}));
    if (rx_if.overrun) ovr_cycles++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic good_par(input logic [DB-1:0] d);
    return (PAR == 1) ? ~^d : ^d;
  endfunction

  function automatic frame_t model(input logic [DB-1:0] d,
                                   input logic pbit,
                                   input logic [1:0] stops);
    frame_t f;
    f.data = d;
    f.ferr = 1'b0;
    for (int i = 0; i < NSTOP; i++)
      if (!stops[i]) f.ferr = 1'b1;
    f.perr = PAR_EN && (pbit != good_par(d));
    return f;
  endfunction

  task automatic send(input logic [DB-1:0] d,
                      input logic pbit,
                      input logic [1:0] stops);
    rxd = 1'b0;
    clks(T_BIT);
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      clks(T_BIT);
    end
    if (PAR_EN) begin
      rxd = pbit;
      clks(T_BIT);
    end
    for (int i = 0; i < NSTOP; i++) begin
      rxd = stops[i];
      clks(T_BIT);
    end
    rxd = 1'b1;
    clks(2 * T_BIT);
  endtask

  task automatic expect_frame(input string tag,
                              input frame_t e);
    frame_t f;
    check({tag, "_cnt"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      f = got_q.pop_front();
      check({tag, "_data"}, f.data, e.data);
      check({tag, "_ferr"}, f.ferr, e.ferr);
      check({tag, "_perr"}, f.perr, e.perr);
    end
    got_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, rx_if.rx_valid, 0);
    check({tag, "_data"}, rx_if.rx_data, 0);
    check({tag, "_ferr"}, rx_if.frame_err, 0);
    check({tag, "_perr"}, rx_if.parity_err, 0);
    check({tag, "_ovr"}, rx_if.overrun, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int o0;
    logic [DB-1:0] d;
    logic pb;
    logic [1:0] st;
    rx_if.rx_ready = 1'b1;
    clks(3);
    check_idle_outputs("rst");
    reset_n = 1'b1;
    clks(4);

    send(8'hA5, good_par(8'hA5), 2'b11);
    expect_frame("basic", model(8'hA5, good_par(8'hA5), 2'b11));
    check("basic_ovr", ovr_cycles, 0);

    rxd = 1'b0;
    clks(12);
    rxd = 1'b1;
    clks(1);
    check("fs_busy_hi", busy, 1);
    clks(T_BIT);
    check("fs_busy_lo", busy, 0);
    check("fs_cnt", got_q.size(), 0);

    send(8'h3C, good_par(8'h3C), 2'b10);
    expect_frame("ferr", model(8'h3C, good_par(8'h3C), 2'b10));
    send(8'h55, good_par(8'h55), 2'b11);
    expect_frame("ferr_ok", model(8'h55, good_par(8'h55), 2'b11));
    send(8'h00, 1'b0, 2'b10);
    expect_frame("break", model(8'h00, 1'b0, 2'b10));

    send(8'h07, 1'b0, 2'b11);
    expect_frame("par0", model(8'h07, 1'b0, 2'b11));
    send(8'h07, 1'b1, 2'b11);
    expect_frame("par1", model(8'h07, 1'b1, 2'b11));

    rx_if.rx_ready = 1'b0;
    o0 = ovr_cycles;
    send(8'h11, good_par(8'h11), 2'b11);
    send(8'h22, good_par(8'h22), 2'b11);
    check("ovr_pulses", ovr_cycles - o0, 1);
    check("ovr_valid", rx_if.rx_valid, 1);
    check("ovr_data", rx_if.rx_data, 8'h11);
    check("ovr_none_out", got_q.size(), 0);
    rx_if.rx_ready = 1'b1;
    clks(1);
    check("ovr_drain", rx_if.rx_valid, 0);
    expect_frame("ovr", model(8'h11, good_par(8'h11), 2'b11));

    fork
      send(8'hF0, good_par(8'hF0), 2'b11);
      begin
        clks(4 * T_BIT + 40);
        reset_n = 1'b0;
        #3;
        check_idle_outputs("mid");
        reset_n = 1'b1;
      end
    join
    check("mid_cnt", got_q.size(), 0);
    got_q.delete();
    send(8'h5A, good_par(8'h5A), 2'b11);
    expect_frame("post", model(8'h5A, good_par(8'h5A), 2'b11));

    for (int n = 0; n < 16; n++) begin
      d  = DB'($urandom);
      pb = good_par(d) ^ ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      send(d, pb, st);
      expect_frame($sformatf("rnd%0d", n), model(d, pb, st));
    end
    check("rnd_ovr", ovr_cycles - o0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
